// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: operand forwarding select and load-use stall generation
// for the pipelined RISC-V core. Tracks in-flight destinations for
// FWD_DEPTH stages after EX (index 0 = EX/MEM, index 1 = MEM/WB, ...).
// Optional macro FWD_HAZARD_STATS_EN adds stall_cycles / fwd_events counters.
module fwd_hazard_unit #(
  parameter int REG_AW    = 5,
  parameter int NUM_SRC   = 2,
  parameter int FWD_DEPTH = 2,
  parameter int LOAD_LAT  = 1,
  parameter int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        advance,
  input  logic                        ex_valid,
  input  logic [NUM_SRC*REG_AW-1:0]   ex_rs,
  input  logic [NUM_SRC-1:0]          ex_rs_used,
  input  logic [REG_AW-1:0]           ex_rd,
  input  logic                        ex_reg_write,
  input  logic                        ex_mem_read,
  input  logic                        ex_flush,
  output logic [NUM_SRC*SEL_W-1:0]    fwd_sel,
  output logic                        stall,
  output logic [FWD_DEPTH-1:0]        busy_mask
`ifdef FWD_HAZARD_STATS_EN
  ,
  output logic [31:0]                 stall_cycles,
  output logic [31:0]                 fwd_events
`endif
);

  // Tracker: control bits are reset, payload (rd) is not.
  logic [FWD_DEPTH-1:0] valid_q;
  logic [FWD_DEPTH-1:0] wr_q;
  logic [FWD_DEPTH-1:0] ld_q;
  logic [REG_AW-1:0]    rd_q [FWD_DEPTH];

  logic                 hazard;
  logic [SEL_W-1:0]     win_sel;
  logic                 win_ld;

  // Per-channel nearest-stage match and load-use hazard detection.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and infers a latch.
    fwd_sel = '0;
    hazard  = 1'b0;
    win_sel = '0;
    win_ld  = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      win_sel = '0;
      win_ld  = 1'b0;
      // Walk oldest to youngest so the nearest match is written last and wins.
      for (int j = FWD_DEPTH - 1; j >= 0; j--) begin
        if (ex_valid && ex_rs_used[i] && valid_q[j] && wr_q[j] &&
            (rd_q[j] != '0) && (rd_q[j] == ex_rs[i*REG_AW +: REG_AW])) begin
          win_sel = SEL_W'(j + 1);
          win_ld  = ld_q[j];
        end
      end
      fwd_sel[i*SEL_W +: SEL_W] = win_sel;
      // Load data is not yet forwardable at stages 1..LOAD_LAT.
      if (win_ld && (int'(win_sel) <= LOAD_LAT)) begin
        hazard = 1'b1;
      end
    end
  end

  // A redirect kills the EX instruction, so it can never need to wait.
  assign stall = hazard && !ex_flush;

  // Occupancy view for the rest of the pipeline.
  assign busy_mask = valid_q & wr_q;

  // Tracker control bits: shift on advance, insert bubble on stall/flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      wr_q    <= '0;
      ld_q    <= '0;
    end else if (advance) begin
      // NOTE: non-blocking assignments make every stage read the pre-edge
      // value of its neighbour, so the shift order in the loop is irrelevant.
      for (int j = FWD_DEPTH - 1; j >= 1; j--) begin
        valid_q[j] <= valid_q[j-1];
        wr_q[j]    <= wr_q[j-1];
        ld_q[j]    <= ld_q[j-1];
      end
      valid_q[0] <= ex_valid && !ex_flush && !stall;
      wr_q[0]    <= ex_reg_write;
      ld_q[0]    <= ex_mem_read;
    end
  end

  // Tracker destination payload: qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    // NOTE: storage-like payload is left unreset; only the valid bits that
    // qualify it must be cleared, which keeps the reset tree small.
    if (advance) begin
      for (int j = FWD_DEPTH - 1; j >= 1; j--) begin
        rd_q[j] <= rd_q[j-1];
      end
      rd_q[0] <= ex_rd;
    end
  end

`ifdef FWD_HAZARD_STATS_EN
  logic [31:0] fwd_inc;

  // Number of channels taking a forwarded value this cycle.
  always_comb begin
    fwd_inc = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if ((fwd_sel[i*SEL_W +: SEL_W] != '0) && !stall && ex_valid) begin
        fwd_inc = fwd_inc + 32'd1;
      end
    end
  end

  // Statistics counters, wrapping modulo 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
      fwd_events   <= '0;
    end else if (advance) begin
      if (stall) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      fwd_events <= fwd_events + fwd_inc;
    end
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: a table of directed vectors on the
// default configuration plus hand-written freeze, async-reset and
// LOAD_LAT=2 / FWD_DEPTH=3 sequences.
module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        advance = 1'b1;
  logic        ex_valid = 1'b0;
  logic [9:0]  ex_rs = '0;
  logic [1:0]  ex_rs_used = '0;
  logic [4:0]  ex_rd = '0;
  logic        ex_reg_write = 1'b0;
  logic        ex_mem_read = 1'b0;
  logic        ex_flush = 1'b0;

  logic [3:0]  fwd_sel;
  logic        stall;
  logic [1:0]  busy_mask;
  logic [3:0]  fwd_sel3;
  logic        stall3;
  logic [2:0]  busy_mask3;
`ifdef FWD_HAZARD_STATS_EN
  logic [31:0] stall_cycles, fwd_events, stall_cycles3, fwd_events3;
`endif

  always #5 clk = ~clk;

  fwd_hazard_unit dut (
    .clk(clk), .reset(reset), .advance(advance), .ex_valid(ex_valid),
    .ex_rs(ex_rs), .ex_rs_used(ex_rs_used), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_flush(ex_flush), .fwd_sel(fwd_sel), .stall(stall),
    .busy_mask(busy_mask)
`ifdef FWD_HAZARD_STATS_EN
    , .stall_cycles(stall_cycles), .fwd_events(fwd_events)
`endif
  );

  fwd_hazard_unit #(.FWD_DEPTH(3), .LOAD_LAT(2)) dut3 (
    .clk(clk), .reset(reset), .advance(advance), .ex_valid(ex_valid),
    .ex_rs(ex_rs), .ex_rs_used(ex_rs_used), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_flush(ex_flush), .fwd_sel(fwd_sel3), .stall(stall3),
    .busy_mask(busy_mask3)
`ifdef FWD_HAZARD_STATS_EN
    , .stall_cycles(stall_cycles3), .fwd_events(fwd_events3)
`endif
  );

  typedef struct packed {
    logic       valid;
    logic [4:0] rs0;
    logic [4:0] rs1;
    logic [1:0] used;
    logic [4:0] rd;
    logic       rw;
    logic       ml;
    logic       fl;
    logic [1:0] sel0;
    logic [1:0] sel1;
    logic       stl;
    logic [1:0] busy;
  } vec_t;

  vec_t vecs [14];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                       input logic [1:0] used, input logic [4:0] rd,
                       input logic rw, input logic ml, input logic fl);
    ex_valid     = v;
    ex_rs        = {rs1, rs0};
    ex_rs_used   = used;
    ex_rd        = rd;
    ex_reg_write = rw;
    ex_mem_read  = ml;
    ex_flush     = fl;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nst;
    //            v  rs0 rs1 used  rd rw ml fl  s0 s1 st busy
    vecs[0]  = '{1, 0, 0, 2'b00, 5, 1, 0, 0, 0, 0, 0, 2'b00};
    vecs[1]  = '{1, 5, 0, 2'b01, 6, 1, 0, 0, 1, 0, 0, 2'b01};
    vecs[2]  = '{1, 6, 5, 2'b11, 7, 1, 0, 0, 1, 2, 0, 2'b11};
    vecs[3]  = '{1, 7, 0, 2'b01, 7, 1, 0, 0, 1, 0, 0, 2'b11};
    vecs[4]  = '{1, 7, 7, 2'b11, 0, 1, 0, 0, 1, 1, 0, 2'b11};
    vecs[5]  = '{1, 0, 7, 2'b11, 0, 1, 0, 0, 0, 2, 0, 2'b11};
    vecs[6]  = '{1, 0, 0, 2'b11, 3, 1, 1, 0, 0, 0, 0, 2'b11};
    vecs[7]  = '{1, 3, 0, 2'b01, 4, 1, 0, 0, 1, 0, 1, 2'b11};
    vecs[8]  = '{1, 3, 0, 2'b01, 4, 1, 0, 0, 2, 0, 0, 2'b10};
    vecs[9]  = '{1, 4, 0, 2'b00, 9, 0, 0, 0, 0, 0, 0, 2'b01};
    vecs[10] = '{1, 9, 4, 2'b11, 3, 1, 1, 0, 0, 2, 0, 2'b10};
    vecs[11] = '{1, 3, 0, 2'b01, 8, 1, 0, 1, 1, 0, 0, 2'b01};
    vecs[12] = '{0, 3, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 2'b10};
    vecs[13] = '{0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset fwd_sel", 32'(fwd_sel), 0);
    check("reset stall", 32'(stall), 0);
    check("reset busy_mask", 32'(busy_mask), 0);
    reset = 1'b0;

    // Table-driven vectors on the default configuration.
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].valid, vecs[i].rs0, vecs[i].rs1, vecs[i].used,
            vecs[i].rd, vecs[i].rw, vecs[i].ml, vecs[i].fl);
      @(negedge clk);
      check($sformatf("v%0d sel0", i), 32'(fwd_sel[1:0]), 32'(vecs[i].sel0));
      check($sformatf("v%0d sel1", i), 32'(fwd_sel[3:2]), 32'(vecs[i].sel1));
      check($sformatf("v%0d stall", i), 32'(stall), 32'(vecs[i].stl));
      check($sformatf("v%0d busy", i), 32'(busy_mask), 32'(vecs[i].busy));
      next_cycle();
    end

    // Freeze with the load at stage 1: stall held, tracker unchanged.
    drive(1, 0, 0, 2'b00, 3, 1, 1, 0);
    next_cycle();
    drive(1, 3, 0, 2'b01, 4, 1, 0, 0);
    advance = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("freeze%0d stall", c), 32'(stall), 1);
      check($sformatf("freeze%0d sel0", c), 32'(fwd_sel[1:0]), 1);
      check($sformatf("freeze%0d busy", c), 32'(busy_mask), 32'b01);
      next_cycle();
    end
    advance = 1'b1;
    @(negedge clk);
    check("release stall", 32'(stall), 1);
    next_cycle();
    @(negedge clk);
    check("after stall", 32'(stall), 0);
    check("after sel0", 32'(fwd_sel[1:0]), 2);
    check("after busy", 32'(busy_mask), 32'b10);
    next_cycle();

    // Asynchronous reset in the middle of a stall.
    drive(1, 0, 0, 2'b00, 3, 1, 1, 0);
    next_cycle();
    drive(1, 3, 0, 2'b01, 4, 1, 0, 0);
    @(negedge clk);
    check("pre-reset stall", 32'(stall), 1);
    #2 reset = 1'b1;
    #1;
    check("async reset stall", 32'(stall), 0);
    check("async reset sel", 32'(fwd_sel), 0);
    check("async reset busy", 32'(busy_mask), 0);
    check("async reset busy3", 32'(busy_mask3), 0);
`ifdef FWD_HAZARD_STATS_EN
    check("async reset stall_cycles", stall_cycles, 0);
`endif
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0);
    next_cycle();
    reset = 1'b0;

    // LOAD_LAT=2, FWD_DEPTH=3: two stall cycles, then forward from stage 3.
    drive(1, 0, 0, 2'b00, 3, 1, 1, 0);
    next_cycle();
    drive(1, 3, 0, 2'b01, 4, 1, 0, 0);
    nst = 0;
    @(negedge clk);
    while (stall3 && nst < 6) begin
      nst++;
      next_cycle();
      @(negedge clk);
    end
    check("lat2 stall count", 32'(nst), 2);
    check("lat2 sel0", 32'(fwd_sel3[1:0]), 3);
    check("lat2 busy", 32'(busy_mask3), 32'b100);
    next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
